// File: rtl/epcs_read_engine.sv
// rtl/epcs_read_engine.sv - EPCS serial flash READ (0x03) engine with a one-byte valid/ready output stream.
// SPI mode 0 master: DCLK is a divided CLOCK_50, DO sampled on rising ticks, DI shifted on falling ticks.
module epcs_read_engine #(
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_CYC = 5,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [23:0]          iAddr,
  input  logic [LEN_WIDTH-1:0] iLen,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [7:0]           oData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oFlash_Clk,
  output logic                 oFlash_nCS,
  output logic                 oFlash_DI,
  input  logic                 iFlash_DO
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_STALL, S_END, S_GUARD
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] GUARD_LAST = 16'(CS_HIGH_CYC - 1);

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [4:0]           bit_q, bit_d;
  logic [31:0]          tx_q, tx_d;
  logic [7:0]           rx_q, rx_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 clk_q, clk_d;
  logic                 ncs_q, ncs_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pending_q, pending_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tick, rise, fall, byte_done, hs;

  always_ff @(posedge CLOCK_50 or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      len_q     <= '0;
      clk_q     <= 1'b0;
      ncs_q     <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      len_q     <= len_d;
      clk_q     <= clk_d;
      ncs_q     <= ncs_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    len_d     = len_q;
    clk_d     = clk_q;
    ncs_d     = ncs_q;
    data_d    = data_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    tick      = (cnt_q == DIV_LAST);
    rise      = 1'b0;
    fall      = 1'b0;
    byte_done = 1'b0;
    hs        = valid_q & iReady;

    if (state_q == S_CMD || state_q == S_ADDR || state_q == S_DATA) begin
      cnt_d = tick ? '0 : cnt_q + 16'd1;
      rise  = tick & ~clk_q;
      fall  = tick & clk_q;
      if (tick) clk_d = ~clk_q;
    end

    if (fall && state_q != S_DATA) begin
      tx_d  = {tx_q[30:0], 1'b0};
      bit_d = bit_q + 5'd1;
    end
    if (rise && state_q == S_DATA) begin
      rx_d  = {rx_q[6:0], iFlash_DO};
      bit_d = bit_q + 5'd1;
      if (bit_q == 5'd7) begin
        byte_done = 1'b1;
        bit_d     = '0;
        len_d     = len_q - LEN_WIDTH'(1);
      end
    end

    // A byte that finds the output register occupied waits in rx_q until the handshake.
    if (hs) valid_d = 1'b0;
    if (hs && pending_q) begin
      data_d    = rx_q;
      valid_d   = 1'b1;
      pending_d = 1'b0;
    end
    if (byte_done) begin
      if (!valid_d) begin
        data_d  = rx_d;
        valid_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (iStart) begin
          if (iLen != '0) begin
            state_d = S_CMD;
            ncs_d   = 1'b0;
            tx_d    = {8'h03, iAddr};
            len_d   = iLen;
            bit_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_CMD: if (fall && bit_q == 5'd7) begin
        state_d = S_ADDR;
        bit_d   = '0;
      end
      S_ADDR: if (fall && bit_q == 5'd23) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (fall && bit_q == 5'd0) begin
        if (len_q == '0) state_d = S_END;
        else if (pending_d) state_d = S_STALL;
      end
      S_STALL: if (hs) begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_END: begin
        // nCS is held one half-period past the last falling edge before release.
        cnt_d = tick ? '0 : cnt_q + 16'd1;
        if (tick) ncs_d = 1'b1;
        if (ncs_d && !valid_d && !pending_d) begin
          done_d  = 1'b1;
          state_d = S_GUARD;
          cnt_d   = '0;
        end
      end
      S_GUARD: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GUARD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d     = (state_d != S_IDLE);
  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oData      = data_q;
  assign oValid     = valid_q;
  assign oFlash_Clk = clk_q;
  assign oFlash_nCS = ncs_q;
  assign oFlash_DI  = tx_q[31];

endmodule

// File: tb/tb_epcs_read_engine.sv
// tb/tb_epcs_read_epcs_read_engine.sv - directed bench for epcs_read_engine at CLK_DIV 2, 1 and 5.
// Each instance talks to a behavioural EPCS model that records the header and serves bytes from fmem.
module tb_epcs_read_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = '0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        ready = 1'b1;

  logic [2:0]  busy_v, done_v, valid_v, fclk_v, fncs_v, fdi_v;
  logic [7:0]  data_v [3];
  logic [31:0] hdr_v [3];
  int          rises_v [3];
  logic [7:0]  fmem [3][8];

  logic [7:0]  rxq [3][$];
  int          vcyc [3] = '{0, 0, 0};
  int          dcnt [3] = '{0, 0, 0};

  int checks = 0;
  int errors = 0;
  int q0, r0, v0, d0, cyc, done_cyc, bcyc;
  int run, hi_min, hi_max, lo_min, lo_max;
  logic prev, seen;
  logic [7:0] exp4 [4];

  always #10 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dev
    logic        busy, done, valid, fclk, fncs, fdi;
    logic        fdo = 1'b0;
    logic [7:0]  data;
    logic [31:0] hdr = '0;
    int          bits = 0;
    int          rises = 0;

    epcs_read_engine #(
      .CLK_DIV    ((k == 0) ? 2 : ((k == 1) ? 1 : 5)),
      .CS_HIGH_CYC(5),
      .LEN_WIDTH  (16)
    ) u_dut (
      .CLOCK_50  (clk),
      .iRst      (rst),
      .iStart    (start[k]),
      .iAddr     (addr),
      .iLen      (len),
      .oBusy     (busy),
      .oDone     (done),
      .oData     (data),
      .oValid    (valid),
      .iReady    (ready),
      .oFlash_Clk(fclk),
      .oFlash_nCS(fncs),
      .oFlash_DI (fdi),
      .iFlash_DO (fdo)
    );

    always @(posedge fclk or posedge fncs) begin
      if (fncs) bits <= 0;
      else begin
        if (bits < 32) hdr <= {hdr[30:0], fdi};
        bits <= bits + 1;
      end
    end
    always @(posedge fclk) rises <= rises + 1;
    always @(negedge fclk)
      if (bits >= 32) fdo <= fmem[k][3'((bits - 32) >> 3)][3'(7 - ((bits - 32) & 7))];

    assign busy_v[k]  = busy;
    assign done_v[k]  = done;
    assign valid_v[k] = valid;
    assign fclk_v[k]  = fclk;
    assign fncs_v[k]  = fncs;
    assign fdi_v[k]   = fdi;
    assign data_v[k]  = data;
    assign hdr_v[k]   = hdr;
    assign rises_v[k] = rises;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (valid_v[k] && ready) rxq[k].push_back(data_v[k]);
      if (valid_v[k]) vcyc[k]++;
      if (done_v[k]) dcnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_read(input int k, input logic [23:0] a, input logic [15:0] n);
    addr = a;
    len = n;
    q0 = rxq[k].size();
    r0 = rises_v[k];
    v0 = vcyc[k];
    d0 = dcnt[k];
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input int k);
    prev = fclk_v[k]; run = 1; seen = 1'b0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    while (done_v[k] !== 1'b1 && cyc < 5000) begin
      step();
      cyc++;
      if (fclk_v[k] == prev) run++;
      else begin
        if (prev) begin
          hi_min = (run < hi_min) ? run : hi_min;
          hi_max = (run > hi_max) ? run : hi_max;
        end else if (seen) begin
          lo_min = (run < lo_min) ? run : lo_min;
          lo_max = (run > lo_max) ? run : lo_max;
        end
        if (fclk_v[k]) seen = 1'b1;
        prev = fclk_v[k];
        run = 1;
      end
    end
    done_cyc = cyc;
    chk("done_seen", {31'd0, done_v[k]}, 32'd1);
    chk("ncs_high_at_done", {31'd0, fncs_v[k]}, 32'd1);
    bcyc = 0;
    while (busy_v[k] && bcyc < 100) begin
      step();
      bcyc++;
    end
  endtask

  initial begin
    repeat (3) step();
    chk("rst_ncs", {31'd0, fncs_v[0]}, 32'd1);
    chk("rst_dclk", {31'd0, fclk_v[0]}, 32'd0);
    chk("rst_di", {31'd0, fdi_v[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("rst_done", {31'd0, done_v[0]}, 32'd0);
    chk("rst_valid", {31'd0, valid_v[0]}, 32'd0);
    chk("rst_data", {24'd0, data_v[0]}, 32'd0);
    rst = 1'b0;
    step();

    // single byte, no backpressure
    fmem[0][0] = 8'hA5;
    start_read(0, 24'h012345, 16'd1);
    chk("s1_busy", {31'd0, busy_v[0]}, 32'd1);
    chk("s1_ncs", {31'd0, fncs_v[0]}, 32'd0);
    chk("s1_di", {31'd0, fdi_v[0]}, 32'd0);
    wait_done(0);
    chk("t1_done_cycle", done_cyc, 32'd163);
    chk("t1_header", hdr_v[0], 32'h03012345);
    chk("t1_dclk_pulses", rises_v[0] - r0, 32'd40);
    chk("t1_rx_count", rxq[0].size() - q0, 32'd1);
    chk("t1_rx_byte", {24'd0, rxq[0][q0]}, 32'hA5);
    chk("t1_valid_cycles", vcyc[0] - v0, 32'd1);
    chk("t1_busy_fall", bcyc, 32'd5);
    chk("t1_done_pulses", dcnt[0] - d0, 32'd1);

    // burst with backpressure
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    for (int i = 0; i < 4; i++) fmem[0][i] = exp4[i];
    start_read(0, 24'h000100, 16'd4);
    while (valid_v[0] !== 1'b1 && cyc < 2000) begin step(); cyc++; end
    ready = 1'b0;
    repeat (40) step();
    chk("t2_stall_rises_40", rises_v[0] - r0, 32'd48);
    repeat (10) step();
    chk("t2_stall_rises_50", rises_v[0] - r0, 32'd48);
    chk("t2_stall_dclk", {31'd0, fclk_v[0]}, 32'd0);
    chk("t2_stall_ncs", {31'd0, fncs_v[0]}, 32'd0);
    chk("t2_stall_data", {24'd0, data_v[0]}, 32'h11);
    ready = 1'b1;
    wait_done(0);
    chk("t2_rx_count", rxq[0].size() - q0, 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_rx_byte", {24'd0, rxq[0][q0 + i]}, {24'd0, exp4[i]});
    chk("t2_header", hdr_v[0], 32'h03000100);
    chk("t2_dclk_pulses", rises_v[0] - r0, 32'd64);

    // zero length
    start_read(0, 24'h000000, 16'd0);
    chk("t3_done", {31'd0, done_v[0]}, 32'd1);
    chk("t3_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("t3_ncs", {31'd0, fncs_v[0]}, 32'd1);
    chk("t3_dclk", {31'd0, fclk_v[0]}, 32'd0);
    step();
    chk("t3_done_clear", {31'd0, done_v[0]}, 32'd0);
    chk("t3_dclk_pulses", rises_v[0] - r0, 32'd0);

    // start while busy is ignored
    fmem[0][0] = 8'h3C;
    fmem[0][1] = 8'hE7;
    start_read(0, 24'h0ABCDE, 16'd1);
    repeat (60) step();
    addr = 24'h777777;
    len = 16'd2;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    cyc = 61;
    wait_done(0);
    chk("t4_header", hdr_v[0], 32'h030ABCDE);
    chk("t4_rx_count", rxq[0].size() - q0, 32'd1);
    chk("t4_rx_byte", {24'd0, rxq[0][q0]}, 32'h3C);
    chk("t4_dclk_pulses", rises_v[0] - r0, 32'd40);
    chk("t4_done_pulses", dcnt[0] - d0, 32'd1);

    // reset during the third data byte
    start_read(0, 24'h000200, 16'd4);
    while (rises_v[0] - r0 < 51 && cyc < 2000) begin step(); cyc++; end
    rst = 1'b1;
    #1;
    chk("t5_ncs", {31'd0, fncs_v[0]}, 32'd1);
    chk("t5_dclk", {31'd0, fclk_v[0]}, 32'd0);
    chk("t5_valid", {31'd0, valid_v[0]}, 32'd0);
    chk("t5_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("t5_data", {24'd0, data_v[0]}, 32'd0);
    step();
    rst = 1'b0;
    step();
    fmem[0][0] = 8'h5A;
    start_read(0, 24'h00FFFF, 16'd1);
    wait_done(0);
    chk("t5_header", hdr_v[0], 32'h0300FFFF);
    chk("t5_rx_count", rxq[0].size() - q0, 32'd1);
    chk("t5_rx_byte", {24'd0, rxq[0][q0]}, 32'h5A);

    // divider 1
    fmem[1][0] = 8'hC3;
    start_read(1, 24'h00ABCD, 16'd1);
    wait_done(1);
    chk("d1_done_cycle", done_cyc, 32'd82);
    chk("d1_hi_min", hi_min, 32'd1);
    chk("d1_hi_max", hi_max, 32'd1);
    chk("d1_lo_min", lo_min, 32'd1);
    chk("d1_lo_max", lo_max, 32'd1);
    chk("d1_header", hdr_v[1], 32'h0300ABCD);
    chk("d1_rx_byte", {24'd0, rxq[1][q0]}, 32'hC3);
    chk("d1_dclk_pulses", rises_v[1] - r0, 32'd40);

    // divider 5
    fmem[2][0] = 8'h96;
    start_read(2, 24'hFEDCBA, 16'd1);
    wait_done(2);
    chk("d5_done_cycle", done_cyc, 32'd406);
    chk("d5_hi_min", hi_min, 32'd5);
    chk("d5_hi_max", hi_max, 32'd5);
    chk("d5_lo_min", lo_min, 32'd5);
    chk("d5_lo_max", lo_max, 32'd5);
    chk("d5_header", hdr_v[2], 32'h03FEDCBA);
    chk("d5_rx_byte", {24'd0, rxq[2][q0]}, 32'h96);
    chk("d5_busy_fall", bcyc, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
